// File: rtl/nb_mode_fill.sv
// Writes a decoded PU's intra mode into the up-row and left-column neighbour RAMs,
// one 4x4 unit per cycle per buffer, and clears the left column at CTB start.
//
// state   | meaning
// S_IDLE  | ready; accepts clr_left (priority) or start; done pulses here
// S_FILL  | cycle k writes up[x0+k] (k<w) and left[y0+k] (k<h), k < max(w,h)
// S_CLEAR | cycle k writes left[k] = CLR_VALUE for every left-column entry
module nb_mode_fill #(
    parameter int                   ROW_ADDR_BITS = 10,
    parameter int                   COL_ADDR_BITS = 4,
    parameter int                   DATA_BITS     = 6,
    parameter logic [DATA_BITS-1:0] CLR_VALUE     = DATA_BITS'(1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clr_left,
    input  logic [ROW_ADDR_BITS-1:0] x0,
    input  logic [COL_ADDR_BITS-1:0] y0,
    input  logic [4:0]               w,
    input  logic [4:0]               h,
    input  logic [DATA_BITS-1:0]     mode,
    output logic                     ready,
    output logic                     done,
    output logic                     up_we,
    output logic [ROW_ADDR_BITS-1:0] up_addr,
    output logic [DATA_BITS-1:0]     up_d,
    output logic                     left_we,
    output logic [COL_ADDR_BITS-1:0] left_addr,
    output logic [DATA_BITS-1:0]     left_d
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam logic [4:0] CLR_LAST = 5'(2 ** COL_ADDR_BITS);

    state_t                   state_q;
    logic [4:0]               cnt_q;
    logic [4:0]               n_q;
    logic [4:0]               w_q;
    logic [4:0]               h_q;
    logic [ROW_ADDR_BITS-1:0] x0_q;
    logic [COL_ADDR_BITS-1:0] y0_q;
    logic [DATA_BITS-1:0]     mode_q;

    logic                     ready_q;
    logic                     done_q;
    logic                     up_we_q;
    logic [ROW_ADDR_BITS-1:0] up_addr_q;
    logic [DATA_BITS-1:0]     up_d_q;
    logic                     left_we_q;
    logic [COL_ADDR_BITS-1:0] left_addr_q;
    logic [DATA_BITS-1:0]     left_d_q;

    logic [4:0]               n_in;

    assign n_in = (w > h) ? w : h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            mode_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            up_we_q     <= 1'b0;
            up_addr_q   <= '0;
            up_d_q      <= '0;
            left_we_q   <= 1'b0;
            left_addr_q <= '0;
            left_d_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    up_we_q   <= 1'b0;
                    left_we_q <= 1'b0;
                    if (clr_left) begin
                        // First clear write is issued straight from the accept edge.
                        state_q     <= S_CLEAR;
                        ready_q     <= 1'b0;
                        cnt_q       <= 5'd1;
                        left_we_q   <= 1'b1;
                        left_addr_q <= '0;
                        left_d_q    <= CLR_VALUE;
                    end else if (start) begin
                        x0_q   <= x0;
                        y0_q   <= y0;
                        w_q    <= w;
                        h_q    <= h;
                        mode_q <= mode;
                        n_q    <= n_in;
                        if (n_in == 5'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= S_FILL;
                            ready_q     <= 1'b0;
                            cnt_q       <= 5'd1;
                            up_we_q     <= (w != 5'd0);
                            up_addr_q   <= x0;
                            up_d_q      <= mode;
                            left_we_q   <= (h != 5'd0);
                            left_addr_q <= y0;
                            left_d_q    <= mode;
                        end
                    end
                end

                S_FILL: begin
                    if (cnt_q == n_q) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        up_we_q   <= 1'b0;
                        left_we_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        // Adding the counter at address width gives the same modulo
                        // result as a full-width sum followed by truncation.
                        up_we_q     <= (cnt_q < w_q);
                        up_addr_q   <= x0_q + ROW_ADDR_BITS'(cnt_q);
                        up_d_q      <= mode_q;
                        left_we_q   <= (cnt_q < h_q);
                        left_addr_q <= y0_q + COL_ADDR_BITS'(cnt_q);
                        left_d_q    <= mode_q;
                        cnt_q       <= cnt_q + 5'd1;
                    end
                end

                S_CLEAR: begin
                    if (cnt_q == CLR_LAST) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        up_we_q   <= 1'b0;
                        left_we_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        up_we_q     <= 1'b0;
                        left_we_q   <= 1'b1;
                        left_addr_q <= COL_ADDR_BITS'(cnt_q);
                        left_d_q    <= CLR_VALUE;
                        cnt_q       <= cnt_q + 5'd1;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    up_we_q   <= 1'b0;
                    left_we_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign up_we     = up_we_q;
    assign up_addr   = up_addr_q;
    assign up_d      = up_d_q;
    assign left_we   = left_we_q;
    assign left_addr = left_addr_q;
    assign left_d    = left_d_q;

endmodule

// File: tb/tb_nb_mode_fill.sv
// Scoreboard bench for nb_mode_fill: expected per-cycle output records are queued
// when a request is issued and compared at each falling edge.
module tb_nb_mode_fill;

    localparam int RB = 10;
    localparam int CB = 4;
    localparam int DB = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clr_left = 1'b0;
    logic [RB-1:0] x0 = '0;
    logic [CB-1:0] y0 = '0;
    logic [4:0]    w = '0;
    logic [4:0]    h = '0;
    logic [DB-1:0] mode = '0;
    logic          ready, done, up_we, left_we;
    logic [RB-1:0] up_addr;
    logic [CB-1:0] left_addr;
    logic [DB-1:0] up_d, left_d;

    // {ready, done, up_we, up_addr, up_d, left_we, left_addr, left_d}
    typedef logic [29:0] rec_t;
    localparam rec_t IDLE_REC = {2'b10, 28'd0};
    localparam rec_t DONE_REC = {2'b11, 28'd0};

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    nb_mode_fill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_left(clr_left),
        .x0(x0), .y0(y0), .w(w), .h(h), .mode(mode),
        .ready(ready), .done(done),
        .up_we(up_we), .up_addr(up_addr), .up_d(up_d),
        .left_we(left_we), .left_addr(left_addr), .left_d(left_d)
    );

    always #5 clk = ~clk;

    // Address/data are only meaningful while the matching write enable is high.
    function automatic rec_t obs();
        return {ready, done,
                up_we, up_we ? up_addr : 10'd0, up_we ? up_d : 6'd0,
                left_we, left_we ? left_addr : 4'd0, left_we ? left_d : 6'd0};
    endfunction

    function automatic rec_t raw_obs();
        return {ready, done, up_we, up_addr, up_d, left_we, left_addr, left_d};
    endfunction

    task automatic push_fill(input int fx, input int fy, input int fw, input int fh, input int fm);
        int   n;
        rec_t r;
        n = (fw > fh) ? fw : fh;
        for (int k = 0; k < n; k++) begin
            r = '0;
            if (k < fw) begin
                r[27]    = 1'b1;
                r[26:17] = 10'((fx + k) % 1024);
                r[16:11] = 6'(fm);
            end
            if (k < fh) begin
                r[10]  = 1'b1;
                r[9:6] = 4'((fy + k) % 16);
                r[5:0] = 6'(fm);
            end
            exp_q.push_back(r);
        end
        exp_q.push_back(DONE_REC);
    endtask

    task automatic push_clear();
        rec_t r;
        for (int k = 0; k < 16; k++) begin
            r = '0;
            r[10]  = 1'b1;
            r[9:6] = 4'(k);
            r[5:0] = 6'd1;
            exp_q.push_back(r);
        end
        exp_q.push_back(DONE_REC);
    endtask

    // Drives one start pulse, then scrambles the request fields to prove they were latched.
    task automatic issue_fill(input int fx, input int fy, input int fw, input int fh, input int fm);
        x0 = RB'(fx); y0 = CB'(fy); w = 5'(fw); h = 5'(fh); mode = DB'(fm);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x0 = RB'($urandom); y0 = CB'($urandom); w = 5'($urandom_range(16));
        h = 5'($urandom_range(16)); mode = DB'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (raw_obs() !== IDLE_REC) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", raw_obs(), IDLE_REC);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (raw_obs() !== IDLE_REC) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, raw_obs(), IDLE_REC);
            end
        end
    endtask

    task automatic test_fill_basic();
        rec_t e, g;
        push_fill(8, 4, 2, 4, 26);
        exp_q.push_back(IDLE_REC);
        issue_fill(8, 4, 2, 4, 26);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL fill_basic got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_wrap();
        rec_t e, g;
        push_fill(1022, 14, 4, 4, 10);
        issue_fill(1022, 14, 4, 4, 10);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL wrap got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_one_port();
        rec_t e, g;
        push_fill(40, 9, 0, 3, 33);
        push_fill(500, 2, 5, 0, 17);
        issue_fill(40, 9, 0, 3, 33);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL one_port_left got=%h exp=%h", g, e);
            end
        end
        issue_fill(500, 2, 5, 0, 17);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL one_port_up got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, g;
        push_clear();
        push_fill(3, 2, 3, 1, 5);
        exp_q.push_back(IDLE_REC);
        x0 = 10'd3; y0 = 4'd2; w = 5'd3; h = 5'd1; mode = 6'd5;
        clr_left = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        clr_left = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL clear_seq cyc=%0d got=%h exp=%h", i, g, e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        x0 = '0; w = 5'd9; h = 5'd9; mode = 6'd63;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL b2b_fill got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_zero_and_busy();
        rec_t e, g;
        exp_q.push_back(DONE_REC);
        exp_q.push_back(IDLE_REC);
        issue_fill(77, 3, 0, 0, 12);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL zero_fill got=%h exp=%h", g, e);
            end
        end
        push_fill(100, 0, 3, 0, 21);
        repeat (3) exp_q.push_back(IDLE_REC);
        issue_fill(100, 0, 3, 0, 21);
        fork
            begin
                @(posedge clk);
                #1;
                x0 = 10'd200; w = 5'd5; h = 5'd5; start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL busy_ignore got=%h exp=%h", g, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        rec_t e, g;
        push_fill(0, 0, 16, 16, 7);
        issue_fill(0, 0, 16, 16, 7);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            g = obs();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL abort_pre cyc=%0d got=%h exp=%h", i, g, e);
            end
        end
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, done, up_we, left_we} !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_async got=%b exp=%b", {ready, done, up_we, left_we}, 4'b1000);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (raw_obs() !== IDLE_REC) begin
                n_err++;
                $display("FAIL abort_post cyc=%0d got=%h exp=%h", i, raw_obs(), IDLE_REC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_wrap();
        test_one_port();
        test_back_to_back();
        test_zero_and_busy();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nb_mode_fill.md
Name: nb_mode_fill

Overview:
- Sequential writer that records a decoded PU's intra prediction mode into the two neighbour-info distributed RAMs: the picture-wide up-row buffer, indexed by x in 4x4 units, and the CTB-local left-column buffer, indexed by y in 4x4 units.
- Sits between the CU/PU syntax parser and the dual-port neighbour RAMs. It drives their write side, one 4x4 unit per cycle per buffer.
- Also re-initialises the left-column buffer at each CTB start.

Parameters:
ROW_ADDR_BITS, 10, up-row buffer address width (picture width / 4, up to 4096 pixels)
COL_ADDR_BITS, 4, left-column buffer address width (CTB 64 / 4)
DATA_BITS, 6, stored mode width (0..34 plus markers)
CLR_VALUE, 6'd1, left-column value written by a clear (DC)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  fill request, sampled only when ready=1
clr_left  input  1  left-column clear request, sampled only when ready=1
x0  input  ROW_ADDR_BITS  PU left edge, picture 4x4 units
y0  input  COL_ADDR_BITS  PU top edge, CTB-local 4x4 units
w  input  5  PU width in 4x4 units (0..16)
h  input  5  PU height in 4x4 units (0..16)
mode  input  DATA_BITS  intra mode to store
ready  output  1  idle, can accept a request
done  output  1  one-cycle pulse, request complete
up_we  output  1  up-row RAM write enable (also drives en)
up_addr  output  ROW_ADDR_BITS  up-row RAM write address
up_d  output  DATA_BITS  up-row RAM write data
left_we  output  1  left-column RAM write enable (also drives en)
left_addr  output  COL_ADDR_BITS  left-column RAM write address
left_d  output  DATA_BITS  left-column RAM write data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0.
  - ready=1, done=0, up_we=0, left_we=0.
  - All address and data outputs reset to 0.
- All outputs are registered.
- Request acceptance in IDLE:
  - clr_left=1 -> CLEAR. clr_left has priority over start.
  - Otherwise start=1 -> FILL.
  - A request that loses priority is not latched; the caller holds or re-issues it.
  - x0, y0, w, h and mode are latched at acceptance. Later input changes have no effect.
- ready=0 from the cycle after acceptance until done. Requests while ready=0 are ignored.
- FILL:
  - n = max(w,h). Cycle k runs for k=0..n-1, starting the cycle after acceptance.
  - up_we = (k<w); up_addr = (x0+k) mod 2^ROW_ADDR_BITS; up_d = mode.
  - left_we = (k<h); left_addr = (y0+k) mod 2^COL_ADDR_BITS; left_d = mode.
  - Both ports write in parallel in the same cycle.
  - Counter is 5 bits; internal address sums use full width, then truncate.
- CLEAR:
  - Runs 2^COL_ADDR_BITS cycles. Cycle k: left_we=1, left_addr=k, left_d=CLR_VALUE; up_we=0.
- Completion:
  - The cycle after the last write cycle: state=IDLE, done=1 for exactly that cycle, ready=1, all we=0.
  - A new request may be accepted in that same done cycle.
- Zero-size fill: w=0 and h=0 -> no write cycles. done pulses the cycle after acceptance.
- If only one of w/h is 0, that port stays idle for the whole fill.
- w or h >16 is not legal input; behaviour then is bounded by the 5-bit counter.
- Latency: a fill takes max(w,h)+1 cycles from acceptance to done. A clear takes 2^COL_ADDR_BITS+1 cycles.
- Reset mid-operation aborts immediately to the reset state. No further writes occur and no done pulse is issued.

Test Plan:
- Reset, then idle 5 cycles -> ready=1, done=0, up_we=left_we=0, addresses 0.
- Fill x0=8, y0=4, w=2, h=4, mode=26 -> 4 write cycles:
  - up_we 1,1,0,0 at up_addr 8,9.
  - left_we 1,1,1,1 at left_addr 4,5,6,7; data 26 throughout.
  - done the 5th cycle after acceptance.
- Wrap: x0=1022, y0=14, w=4, h=4, mode=10 -> up_addr 1022,1023,0,1; left_addr 14,15,0,1.
- clr_left and start asserted together -> 16 writes of 1 to left_addr 0..15, up_we=0; start ignored. Re-issued start in the done cycle is accepted and begins writes the next cycle.
- Fill w=0, h=0 -> no writes, done the cycle after acceptance. A second start while ready=0 produces no extra writes.
- Fill w=16, h=16; assert rst_n=0 at write cycle 5 -> we drops asynchronously, no done. After release ready=1 with no stray writes.
